linear_regression_estimation: RTL and testbench
===============================================

Name: linear_regression_estimation

Overview:
Streaming least-squares line fitter. It accepts up to RAM_DEPTH paired integer samples (x, z) and accumulates the running sums on the fly. After the last pair it computes slope theta1 and intercept theta0 of z = theta0 + theta1*x using sequential signed division. It sits after a sample-capture front end and presents a held result with a valid flag.

Parameters:
DATA_WIDTH, 32, width of each sample and of each theta output (signed two's complement).
RAM_DEPTH, 35, maximum pairs per estimation; legal range 2..256.
Derived (localparam): SUM_W = 2*DATA_WIDTH+8 for all sums; NUM_W = 2*DATA_WIDTH+16 for the numerator, denominator and divider.

Ports:
i_clock  in  1  system clock; all logic rising-edge.
i_reset  in  1  asynchronous active-low reset.
i_samples_x_in  in  DATA_WIDTH  x sample, signed.
i_samples_x_vld  in  1  x sample valid.
i_samples_x_last  in  1  marks the final x sample.
i_samples_z_in  in  DATA_WIDTH  z sample, signed.
i_samples_z_vld  in  1  z sample valid.
i_samples_z_last  in  1  marks the final z sample.
i_data_samples_n  in  DATA_WIDTH  expected pair count; captured with the first accepted pair.
o_theta0_out  out  DATA_WIDTH  intercept, signed.
o_theta1_out  out  DATA_WIDTH  slope, signed.
o_theta_out_vld  out  1  result valid (level, held).

Behaviour:
- Reset (i_reset=0, asynchronous): FSM goes to IDLE; all sums and the count are 0; o_theta0_out=0, o_theta1_out=0, o_theta_out_vld=0. Reset mid-computation aborts the computation with no partial output.
- A pair is accepted on a clock edge when i_samples_x_vld and i_samples_z_vld are both 1 and the FSM is in IDLE or ACCUM. A lone x or lone z valid is ignored.
- The first accepted pair clears o_theta_out_vld, captures N_exp = i_data_samples_n, and moves the FSM IDLE to ACCUM.
- Each accepted pair updates: Sx+=x, Sz+=z, Sxx+=x*x, Sxz+=x*z (signed, SUM_W bits), and count+=1.
- The load ends on the accepted pair that satisfies any of: x_last or z_last is set; count reaches N_exp; count reaches RAM_DEPTH. Pairs arriving after that are ignored until DONE.
- FSM: IDLE -> ACCUM -> PREP1 -> DIV1 -> PREP0 -> DIV0 -> DONE -> IDLE.
- PREP1 (1 cycle): num1 = N*Sxz - Sx*Sz; den1 = N*Sxx - Sx*Sx (NUM_W signed).
- DIV1 (NUM_W cycles): restoring divide of magnitudes, one quotient bit per cycle, sign applied at the end; truncates toward zero. theta1 = num1/den1.
- PREP0 (1 cycle): num0 = Sz - theta1*Sx, using the already-saturated theta1; den0 = N.
- DIV0 (NUM_W cycles): theta0 = num0/N, truncated toward zero.
- DONE (1 cycle): registers both results and asserts o_theta_out_vld. The FSM returns to IDLE.
- Outputs and vld then hold until the next accepted pair or reset.
- Latency: o_theta_out_vld is high exactly 2*NUM_W+3 edges after the edge that accepted the last pair (163 edges for DATA_WIDTH=32).
- Saturation: a quotient outside the signed DATA_WIDTH range clamps to the signed max or min.
- den1 == 0 (N=1, or all x equal): theta1 = 0; theta0 = Sz/N. No divider error.
- N_exp of 0 is treated as RAM_DEPTH.

Optional Feature:
- Macro LR_ROUND_NEAREST_EN.
- When defined: both divisions round to nearest, with halves rounded away from zero. Implemented by adding |den|/2 to |num| before dividing.
- When undefined: both divisions truncate toward zero.
- Latency is identical in both builds.

Test Plan:
- Line fit: x=0..34, z=2x+3, N=35, last on the 35th pair -> theta1=2, theta0=3, vld high 163 cycles after the last pair.
- Negative slope: x=0..34, z=100-3x -> theta1=0xFFFFFFFD (-3), theta0=100.
- Rounding: x={0,1,2}, z={0,1,1}, last on the 3rd pair. Truncate build -> theta1=0, theta0=0. LR_ROUND_NEAREST_EN build -> theta1=1, theta0=0.
- Degenerate input: x=5 for all 4 pairs, z={4,8,12,16} -> theta1=0, theta0=10.
- Count limit: i_data_samples_n=3 with no last flags; stream x=1..10, z=x+1 -> only the first 3 pairs are used: theta1=1, theta0=1. Later pairs are ignored.
- Reset during DIV1: vld stays 0 and outputs stay 0. A fresh 35-pair line fit afterwards gives correct values.

Source files
------------

// File: rtl/linear_regression_estimation.sv
// rtl/linear_regression_estimation.sv - streaming least-squares line fitter (theta0 + theta1*x)
// Optional build macro LR_ROUND_NEAREST_EN: round-half-away-from-zero divisions instead of truncation.
module linear_regression_estimation #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 35
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_samples_x_in,
  input  logic                  i_samples_x_vld,
  input  logic                  i_samples_x_last,
  input  logic [DATA_WIDTH-1:0] i_samples_z_in,
  input  logic                  i_samples_z_vld,
  input  logic                  i_samples_z_last,
  input  logic [DATA_WIDTH-1:0] i_data_samples_n,
  output logic [DATA_WIDTH-1:0] o_theta0_out,
  output logic [DATA_WIDTH-1:0] o_theta1_out,
  output logic                  o_theta_out_vld
);

  localparam int SUM_W  = 2*DATA_WIDTH + 8;
  localparam int NUM_W  = 2*DATA_WIDTH + 16;
  localparam int CNT_W  = $clog2(RAM_DEPTH + 1);
  localparam int DIV_CW = $clog2(NUM_W);

`ifdef LR_ROUND_NEAREST_EN
  localparam logic ROUND = 1'b1;
`else
  localparam logic ROUND = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_PREP1, S_DIV1, S_PREP0, S_DIV0, S_DONE
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         n_exp;
  logic signed [SUM_W-1:0]  sum_x, sum_z, sum_xx, sum_xz;
  logic [NUM_W-1:0]         div_q;
  logic [NUM_W-1:0]         div_r;
  logic [NUM_W-1:0]         div_d;
  logic                     div_neg;
  logic                     div_zero;
  logic [DIV_CW-1:0]        div_cnt;
  logic [DATA_WIDTH-1:0]    theta1_r;

  // Magnitude of a signed numerator/denominator.
  function automatic logic [NUM_W-1:0] mag(input logic signed [NUM_W-1:0] v);
    return v[NUM_W-1] ? NUM_W'(-v) : NUM_W'(v);
  endfunction

  // Apply the sign to an unsigned quotient and clamp it to the signed output range.
  function automatic logic [DATA_WIDTH-1:0] sat_q(input logic [NUM_W-1:0] q, input logic neg);
    logic [NUM_W-1:0] lim_pos;
    lim_pos = '0;
    lim_pos[DATA_WIDTH-2:0] = '1;
    if (neg) begin
      if (q > lim_pos + NUM_W'(1)) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
      return -q[DATA_WIDTH-1:0];
    end
    if (q > lim_pos) return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return q[DATA_WIDTH-1:0];
  endfunction

  logic                    accept, first, load_end;
  logic [CNT_W-1:0]        n_in_eff, n_lim, cnt_next;
  logic signed [SUM_W-1:0] x_s, z_s, xx, xz;
  logic signed [SUM_W-1:0] bx, bz, bxx, bxz;
  logic signed [NUM_W-1:0] n_w, sx_w, sz_w, sxx_w, sxz_w, t1_w;
  logic signed [NUM_W-1:0] num1, den1, num0, dvd, dvs;
  logic [DATA_WIDTH-1:0]   t1_sat;
  logic [NUM_W-1:0]        mag_dvd, mag_dvs, div_seed;
  logic [NUM_W:0]          shifted;
  logic                    ge;
  logic [NUM_W-1:0]        diff;

  // Sample acceptance, end-of-load detection, normal-equation terms and divider step.
  always_comb begin
    accept   = i_samples_x_vld & i_samples_z_vld & ((state == S_IDLE) | (state == S_ACCUM));
    first    = (state == S_IDLE);
    n_in_eff = ((i_data_samples_n == '0) || (i_data_samples_n > DATA_WIDTH'(RAM_DEPTH)))
               ? CNT_W'(RAM_DEPTH) : i_data_samples_n[CNT_W-1:0];
    n_lim    = first ? n_in_eff : n_exp;
    cnt_next = (first ? '0 : count) + CNT_W'(1);
    load_end = i_samples_x_last | i_samples_z_last | (cnt_next == n_lim) |
               (cnt_next == CNT_W'(RAM_DEPTH));

    x_s = {{(SUM_W-DATA_WIDTH){i_samples_x_in[DATA_WIDTH-1]}}, i_samples_x_in};
    z_s = {{(SUM_W-DATA_WIDTH){i_samples_z_in[DATA_WIDTH-1]}}, i_samples_z_in};
    xx  = x_s * x_s;
    xz  = x_s * z_s;
    // A new estimation starts from zero sums rather than the previous run's totals.
    bx  = first ? '0 : sum_x;
    bz  = first ? '0 : sum_z;
    bxx = first ? '0 : sum_xx;
    bxz = first ? '0 : sum_xz;

    n_w   = {{(NUM_W-CNT_W){1'b0}}, count};
    sx_w  = {{(NUM_W-SUM_W){sum_x[SUM_W-1]}}, sum_x};
    sz_w  = {{(NUM_W-SUM_W){sum_z[SUM_W-1]}}, sum_z};
    sxx_w = {{(NUM_W-SUM_W){sum_xx[SUM_W-1]}}, sum_xx};
    sxz_w = {{(NUM_W-SUM_W){sum_xz[SUM_W-1]}}, sum_xz};
    num1  = n_w * sxz_w - sx_w * sz_w;
    den1  = n_w * sxx_w - sx_w * sx_w;

    // A zero slope denominator (all x equal) yields a zero slope.
    t1_sat = div_zero ? '0 : sat_q(div_q, div_neg);
    t1_w   = {{(NUM_W-DATA_WIDTH){t1_sat[DATA_WIDTH-1]}}, t1_sat};
    num0   = sz_w - t1_w * sx_w;

    dvd      = (state == S_PREP1) ? num1 : num0;
    dvs      = (state == S_PREP1) ? den1 : n_w;
    mag_dvd  = mag(dvd);
    mag_dvs  = mag(dvs);
    div_seed = mag_dvd + (ROUND ? (mag_dvs >> 1) : '0);

    shifted = {div_r, div_q[NUM_W-1]};
    ge      = shifted >= {1'b0, div_d};
    diff    = shifted[NUM_W-1:0] - div_d;
  end

  // Control FSM with accumulators, shared restoring divider and registered results.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state           <= S_IDLE;
      count           <= '0;
      n_exp           <= '0;
      sum_x           <= '0;
      sum_z           <= '0;
      sum_xx          <= '0;
      sum_xz          <= '0;
      div_q           <= '0;
      div_r           <= '0;
      div_d           <= '0;
      div_neg         <= 1'b0;
      div_zero        <= 1'b0;
      div_cnt         <= '0;
      theta1_r        <= '0;
      o_theta0_out    <= '0;
      o_theta1_out    <= '0;
      o_theta_out_vld <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            if (first) begin
              o_theta_out_vld <= 1'b0;
              n_exp           <= n_in_eff;
            end
            sum_x  <= bx + x_s;
            sum_z  <= bz + z_s;
            sum_xx <= bxx + xx;
            sum_xz <= bxz + xz;
            count  <= cnt_next;
            state  <= load_end ? S_PREP1 : S_ACCUM;
          end
        end
        S_PREP1, S_PREP0: begin
          if (state == S_PREP0) theta1_r <= t1_sat;
          div_q    <= div_seed;
          div_r    <= '0;
          div_d    <= mag_dvs;
          div_neg  <= dvd[NUM_W-1] ^ dvs[NUM_W-1];
          div_zero <= (dvs == '0);
          div_cnt  <= '0;
          state    <= (state == S_PREP1) ? S_DIV1 : S_DIV0;
        end
        S_DIV1, S_DIV0: begin
          div_r   <= ge ? diff : shifted[NUM_W-1:0];
          div_q   <= {div_q[NUM_W-2:0], ge};
          div_cnt <= div_cnt + DIV_CW'(1);
          if (div_cnt == DIV_CW'(NUM_W-1))
            state <= (state == S_DIV1) ? S_PREP0 : S_DONE;
        end
        S_DONE: begin
          o_theta1_out    <= theta1_r;
          o_theta0_out    <= sat_q(div_q, div_neg);
          o_theta_out_vld <= 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_regression_estimation.sv
// tb/tb_linear_regression_estimation.sv - scoreboard bench for linear_regression_estimation
module tb_linear_regression_estimation;

  localparam int DW    = 32;
  localparam int NUM_W = 2*DW + 16;
  localparam int LAT   = 2*NUM_W + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] x_in, z_in, n_in;
  logic          x_vld, x_last, z_vld, z_last;
  logic [DW-1:0] theta0, theta1;
  logic          vld;

  always #5 clk = ~clk;

  linear_regression_estimation #(.DATA_WIDTH(DW), .RAM_DEPTH(35)) dut (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_samples_x_in  (x_in),
    .i_samples_x_vld (x_vld),
    .i_samples_x_last(x_last),
    .i_samples_z_in  (z_in),
    .i_samples_z_vld (z_vld),
    .i_samples_z_last(z_last),
    .i_data_samples_n(n_in),
    .o_theta0_out    (theta0),
    .o_theta1_out    (theta1),
    .o_theta_out_vld (vld)
  );

  typedef struct {
    logic [DW-1:0] t0;
    logic [DW-1:0] t1;
    int            edge_exp;
    int            id;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  logic vld_prev = 1'b0;
  int   tx[64];
  int   tz[64];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s case %0d: got 0x%0h expected 0x%0h", name, id, act, exp_v);
    end
  endtask

  // Monitor: every rising result-valid is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      vld_prev = 1'b0;
    end else begin
      if (vld && !vld_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_vld", -1, 64'(vld), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("theta1", e.id, 64'(theta1), 64'(e.t1));
          chk("theta0", e.id, 64'(theta0), 64'(e.t0));
          chk("latency", e.id, 64'(edge_cnt), 64'(e.edge_exp));
        end
      end
      vld_prev = vld;
    end
  end

  // lastsel: 0 none, 1 x_last, 2 z_last on the final driven pair; noise inserts lone-x cycles.
  task automatic run(input int id, input int npairs, input int used, input int lastsel,
                     input int nexp, input bit noise, input bit push,
                     input int e_t0, input int e_t1);
    int last_edge = 0;
    for (int i = 0; i < npairs; i++) begin
      if (noise) begin
        @(negedge clk);
        x_in = 32'd999; x_vld = 1'b1; z_vld = 1'b0; x_last = 1'b1; z_last = 1'b0;
      end
      @(negedge clk);
      if (i == 1) chk("vld_clear", id, 64'(vld), 64'(0));
      x_in   = tx[i];
      z_in   = tz[i];
      n_in   = nexp;
      x_vld  = 1'b1;
      z_vld  = 1'b1;
      x_last = (lastsel == 1) && (i == npairs - 1);
      z_last = (lastsel == 2) && (i == npairs - 1);
      if (i == used - 1) last_edge = edge_cnt + 1;
    end
    @(negedge clk);
    x_vld = 1'b0; z_vld = 1'b0; x_last = 1'b0; z_last = 1'b0;
    if (push) sb.push_back('{t0: e_t0, t1: e_t1, edge_exp: last_edge + LAT, id: id});
  endtask

  task automatic drain(input int id);
    for (int c = 0; c < 400 && sb.size() != 0; c++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout", id, 64'(sb.size()), 64'(0));
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic fill_line(input int a, input int b);
    for (int i = 0; i < 35; i++) begin
      tx[i] = i;
      tz[i] = a*i + b;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    x_in = '0; z_in = '0; n_in = '0;
    x_vld = 1'b0; z_vld = 1'b0; x_last = 1'b0; z_last = 1'b0;
    #1;
    chk("reset_vld", 0, 64'(vld), 64'(0));
    chk("reset_theta0", 0, 64'(theta0), 64'(0));
    chk("reset_theta1", 0, 64'(theta1), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill_line(2, 3);
    run(1, 35, 35, 1, 35, 1'b0, 1'b1, 3, 2);
    drain(1);

    fill_line(-3, 100);
    run(2, 35, 35, 2, 0, 1'b0, 1'b1, 100, -3);
    drain(2);

    tx[0] = 0; tx[1] = 1; tx[2] = 2;
    tz[0] = 0; tz[1] = 1; tz[2] = 1;
`ifdef LR_ROUND_NEAREST_EN
    run(3, 3, 3, 1, 0, 1'b0, 1'b1, 0, 1);
`else
    run(3, 3, 3, 1, 0, 1'b0, 1'b1, 0, 0);
`endif
    drain(3);

    tz[0] = 0; tz[1] = -1; tz[2] = -1;
`ifdef LR_ROUND_NEAREST_EN
    run(4, 3, 3, 2, 0, 1'b0, 1'b1, 0, -1);
`else
    run(4, 3, 3, 2, 0, 1'b0, 1'b1, 0, 0);
`endif
    drain(4);

    for (int i = 0; i < 4; i++) begin
      tx[i] = 5;
      tz[i] = 4*(i + 1);
    end
    run(5, 4, 4, 1, 0, 1'b1, 1'b1, 10, 0);
    drain(5);

    for (int i = 0; i < 10; i++) begin
      tx[i] = i + 1;
      tz[i] = i + 2;
    end
    run(6, 10, 3, 0, 3, 1'b0, 1'b1, 1, 1);
    drain(6);

    tx[0] = 0; tx[1] = 1;
    tz[0] = 32'h8000_0000; tz[1] = 32'h7FFF_FFFF;
    run(7, 2, 2, 1, 2, 1'b0, 1'b1, 32'hC000_0000, 32'h7FFF_FFFF);
    drain(7);

    fill_line(2, 3);
    run(8, 35, 35, 1, 35, 1'b0, 1'b0, 0, 0);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_vld", 8, 64'(vld), 64'(0));
    chk("abort_theta0", 8, 64'(theta0), 64'(0));
    chk("abort_theta1", 8, 64'(theta1), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("abort_vld_stays_low", 8, 64'(vld), 64'(0));

    fill_line(2, 3);
    run(9, 35, 35, 1, 35, 1'b0, 1'b1, 3, 2);
    drain(9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
